// File: rtl/fx68k_alu_seq_pkg.sv
// Shared types and constants for the fx68k ALU step sequencer.
// Used by fx68k_alu_seq and fx68k_step_counter.
package fx68k_alu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_FINAL,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_DIV   = 2'b01;
  localparam logic [1:0] OP_SHIFT = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [2:0] COL_NONE  = 3'd0;
  localparam logic [2:0] COL_AND   = 3'd1;
  localparam logic [2:0] COL_ADD   = 3'd2;
  localparam logic [2:0] COL_SHIFT = 3'd4;

  localparam logic [5:0] MUL_STEPS = 6'd16;
  localparam logic [5:0] DIV_STEPS = 6'd32;

  // Reserved opcode falls into the shift path.
  function automatic logic [5:0] load_steps(
    input logic [1:0] op,
    input logic [5:0] cnt
  );
    logic [5:0] r;
    unique case (op)
      OP_MUL:  r = MUL_STEPS;
      OP_DIV:  r = DIV_STEPS;
      default: r = cnt;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fx68k_step_counter.sv
// 6-bit iteration counter: load, saturating decrement, is-one flag.
// Part of fx68k_alu_seq.
module fx68k_step_counter
  import fx68k_alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  logic [5:0] load_val,
  input  logic       dec,
  output logic [5:0] cnt,
  output logic       is_one
);

  logic [5:0] cnt_q;
  logic [5:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 6'd0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 6'd0)) begin
      cnt_d = cnt_q - 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 6'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign is_one = (cnt_q == 6'd1);

endmodule

// File: rtl/fx68k_alu_seq.sv
// fx68k MUL/DIV/SHIFT ALU step sequencer, Moore outputs, enT3 paced.
// Optional FX68K_ALU_SEQ_EARLY_EXIT_EN: ze=0 ends MUL/SHIFT early.
module fx68k_alu_seq
  import fx68k_alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       pwrUp,
  input  logic       enT3,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] opKind,
  input  logic [5:0] count,
  input  logic       ze,
  output logic [2:0] aluColumn,
  output logic [1:0] aluDataCtrl,
  output logic       aluAddrCtrl,
  output logic       alueClkEn,
  output logic       init,
  output logic       finish,
  output logic       busy,
  output logic       done
);

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [5:0] cnt_lat_q, cnt_lat_d;
  logic       ld, dec, clr;
  logic       early;
  logic [5:0] steps;
  logic [5:0] cnt;
  logic       is_one;
  logic       is_div;

  assign steps  = load_steps(op_q, cnt_lat_q);
  assign is_div = (op_q == OP_DIV);

`ifdef FX68K_ALU_SEQ_EARLY_EXIT_EN
  assign early = !is_div && !ze;
`else
  logic unused_ze;
  assign unused_ze = ze;
  assign early     = 1'b0;
`endif

  fx68k_step_counter u_cnt (
    .clk      (clk),
    .rst      (pwrUp),
    .clr      (clr),
    .load     (ld),
    .load_val (steps),
    .dec      (dec),
    .cnt      (cnt),
    .is_one   (is_one)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_lat_d = cnt_lat_q;
    ld        = 1'b0;
    dec       = 1'b0;
    clr       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d   = S_LOAD;
          op_d      = opKind;
          cnt_lat_d = count;
        end
      end
      S_LOAD: begin
        if (enT3) begin
          ld      = 1'b1;
          state_d = (steps == 6'd0) ? S_FINAL : S_ITER;
        end
      end
      S_ITER: begin
        if (enT3) begin
          dec = 1'b1;
          if (is_one || early) state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        if (enT3) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything once a sequence is running.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      ld      = 1'b0;
      dec     = 1'b0;
      clr     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pwrUp) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MUL;
      cnt_lat_q <= 6'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_lat_q <= cnt_lat_d;
    end
  end

  always_comb begin
    aluColumn   = COL_NONE;
    aluDataCtrl = 2'b00;
    aluAddrCtrl = 1'b0;
    alueClkEn   = 1'b0;
    init        = 1'b0;
    finish      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        alueClkEn = 1'b1;
        init      = 1'b1;
        busy      = 1'b1;
      end
      S_ITER: begin
        busy        = 1'b1;
        aluAddrCtrl = 1'b1;
        // Divide alternates shift (even count) and subtract (odd).
        aluColumn   = (is_div && cnt[0]) ? COL_ADD : COL_SHIFT;
      end
      S_FINAL: begin
        busy      = 1'b1;
        aluColumn = COL_AND;
        finish    = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fx68k_alu_seq.sv
// Scoreboard bench for fx68k_alu_seq: expected step records queued
// at issue, popped by a monitor on each enT3 step and done pulse.
module tb_fx68k_alu_seq;

  logic       clk = 1'b0;
  logic       pwrUp;
  logic       enT3;
  logic       start;
  logic       abort;
  logic [1:0] opKind;
  logic [5:0] count;
  logic       ze;
  logic [2:0] aluColumn;
  logic [1:0] aluDataCtrl;
  logic       aluAddrCtrl;
  logic       alueClkEn;
  logic       init;
  logic       finish;
  logic       busy;
  logic       done;

  fx68k_alu_seq dut (
    .clk         (clk),
    .pwrUp       (pwrUp),
    .enT3        (enT3),
    .start       (start),
    .abort       (abort),
    .opKind      (opKind),
    .count       (count),
    .ze          (ze),
    .aluColumn   (aluColumn),
    .aluDataCtrl (aluDataCtrl),
    .aluAddrCtrl (aluAddrCtrl),
    .alueClkEn   (alueClkEn),
    .init        (init),
    .finish      (finish),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int ph = 0;
  always @(posedge clk) begin
    #1;
    ph   = (ph + 1) % 4;
    enT3 = (ph == 0);
  end

  typedef struct packed {
    logic [2:0] col;
    logic [1:0] dc;
    logic       ac;
    logic       ce;
    logic       ini;
    logic       fin;
    logic       dn;
  } rec_t;

  rec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  wire [10:0] outs = {aluColumn, aluDataCtrl, aluAddrCtrl, alueClkEn,
                      init, finish, busy, done};

  always @(negedge clk) begin
    if (!pwrUp && ((busy && enT3) || done)) begin
      rec_t a;
      rec_t e;
      a = {aluColumn, aluDataCtrl, aluAddrCtrl, alueClkEn,
           init, finish, done};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_step got=%h want=none t=%0t", a, $time);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL step_rec got=%h want=%h t=%0t", a, e, $time);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  function automatic rec_t mk(input logic [2:0] col, input logic ac,
                              input logic ce, input logic ini,
                              input logic fin, input logic dn);
    rec_t r;
    r = {col, 2'b00, ac, ce, ini, fin, dn};
    return r;
  endfunction

  task automatic run(input string nm, input logic [1:0] op,
                     input logic [5:0] cnt, input int ze_step,
                     input int kill_step, input bit kill_rst,
                     input bit hold_start);
    rec_t lst[$];
    int   nn, iters, nsteps, n, guard, c;
    bit   e;
    nn    = (op == 2'b00) ? 16 : (op == 2'b01) ? 32 : int'(cnt);
    iters = nn;
`ifdef FX68K_ALU_SEQ_EARLY_EXIT_EN
    if (ze_step > 0 && op != 2'b01 && ze_step < nn) iters = ze_step;
`endif
    lst.push_back(mk(3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < iters; i++) begin
      c = nn - i;
      lst.push_back(mk((op == 2'b01 && (c % 2) == 1) ? 3'd2 : 3'd4,
                       1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    lst.push_back(mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    lst.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    nsteps = iters + 2;
    if (kill_step > 0) begin
      while (lst.size() > kill_step) void'(lst.pop_back());
      nsteps = kill_step;
    end
    foreach (lst[i]) exp_q.push_back(lst[i]);

    @(posedge clk);
    #1;
    start  = 1'b1;
    opKind = op;
    count  = cnt;
    ze     = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_start) start = 1'b0;
    opKind = op ^ 2'b01;
    count  = ~cnt;

    n     = 0;
    guard = 0;
    forever begin
      @(negedge clk);
      e = enT3 && busy;
      @(posedge clk);
      #1;
      guard++;
      if (e) n++;
      if (ze_step > 0 && n == ze_step) ze = 1'b0;
      if (kill_step > 0 && n == kill_step) begin
        if (kill_rst) begin
          pwrUp = 1'b1;
        end else begin
          abort = 1'b1;
          start = 1'b1;
        end
        @(posedge clk);
        #1;
        pwrUp = 1'b0;
        abort = 1'b0;
        start = 1'b0;
        chk({nm, "_killed_outs"}, 32'(outs), 32'd0);
        break;
      end
      if (done) start = 1'b0;
      if (n > 0 && !busy && !done) break;
      if (guard > 1000) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout got=%0d steps want=%0d", nm, n, nsteps);
        break;
      end
    end
    ze    = 1'b1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk({nm, "_idle_outs"}, 32'(outs), 32'd0);
    chk({nm, "_queue_left"}, exp_q.size(), 32'd0);
    chk({nm, "_steps"}, n, nsteps);
    exp_q.delete();
  endtask

  initial begin
    pwrUp  = 1'b1;
    enT3   = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    opKind = 2'b00;
    count  = 6'd0;
    ze     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 32'(outs), 32'd0);
    pwrUp = 1'b0;

    // abort in IDLE blocks a simultaneous start
    @(posedge clk);
    #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("idle_abort_start", 32'(busy), 32'd0);

    run("mul",       2'b00, 6'd0,  0, 0,  1'b0, 1'b0);
    run("div",       2'b01, 6'd0,  0, 0,  1'b0, 1'b0);
    run("shift0",    2'b10, 6'd0,  0, 0,  1'b0, 1'b0);
    run("shift63",   2'b10, 6'd63, 0, 0,  1'b0, 1'b0);
    run("shift1",    2'b10, 6'd1,  0, 0,  1'b0, 1'b0);
    run("rsvd5_hold", 2'b11, 6'd5, 0, 0,  1'b0, 1'b1);
    run("mul_abort", 2'b00, 6'd0,  0, 5,  1'b0, 1'b0);
    run("div_reset", 2'b01, 6'd0,  0, 10, 1'b1, 1'b0);
    run("div_again", 2'b01, 6'd0,  0, 0,  1'b0, 1'b0);
    run("mul_ze3",   2'b00, 6'd0,  3, 0,  1'b0, 1'b0);
    run("div_ze3",   2'b01, 6'd0,  3, 0,  1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
